grid_cursor_ctrl: RTL and testbench
===================================

# grid_cursor_ctrl

Parametrised cursor controller for grid-based VGA games: takes raw directional and action pushbuttons, synchronises and debounces them, and maintains the selected cell (x_select, y_select) with saturate or wrap-around edges and hold-to-repeat. It replaces the ad-hoc cursor logic on a divided clock in the VGA top level. It runs in the system clock domain, and its outputs feed videoGen and the game logic directly.

## Interface
- COLS, 8: grid width in cells (>=2)
- ROWS, 8: grid height in cells (>=2)
- X_W, $clog2(COLS): width of x_select
- Y_W, $clog2(ROWS): width of y_select
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a button level change (>=1)
- REPEAT_DELAY, 25000000: hold cycles after the first step before auto-repeat begins; 0 disables repeat
- REPEAT_RATE, 5000000: cycles between auto-repeat steps (>=1)
- WRAP, 0: 0 = saturate at grid edges, 1 = wrap to the opposite edge
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- arriba, abajo, izquierda, derecha  in  1 each  raw directional buttons, active-high, asynchronous to clk
- mostrar, mostrar_flag  in  1 each  raw reveal and flag buttons, active-high, asynchronous
- x_select  out  X_W  cursor column, 0..COLS-1
- y_select  out  Y_W  cursor row, 0..ROWS-1 (0 = top)
- move_pulse  out  1  one-cycle pulse when the cursor position actually changed on that edge
- reveal_pulse  out  1  one-cycle pulse on an accepted mostrar press
- flag_pulse  out  1  one-cycle pulse on an accepted mostrar_flag press

## Operation
- Input conditioning per button (6 channels):
  - 2-flop synchroniser.
  - Debounce: debounced level d toggles when the synchronised level differs from d for DEBOUNCE_CYCLES consecutive cycles. The counter clears whenever the synchronised level equals d.
- Repeat FSM per direction (4 instances). States IDLE, DELAY, REPEAT; counter width fits max(REPEAT_DELAY, REPEAT_RATE).
  - IDLE: on d rising, issue one step request, clear counter, go to DELAY.
  - DELAY: if REPEAT_DELAY==0, stay (no repeat). Otherwise, when counter==REPEAT_DELAY-1, issue a step, clear counter, go to REPEAT.
  - REPEAT: when counter==REPEAT_RATE-1, issue a step and clear counter.
  - Any state: d low forces IDLE, and no step is issued that cycle.
- Axis resolution:
  - arriba and abajo step requests on the same cycle cancel, leaving y unchanged. Likewise izquierda and derecha for x.
  - One x step and one y step on the same cycle are both applied.
- Edges:
  - WRAP=0: step beyond 0 or COLS-1 / ROWS-1 is ignored.
  - WRAP=1: decrement from 0 goes to COLS-1 (or ROWS-1); increment from the max goes to 0. Arithmetic is compare-based, not modulo 2^X_W, so non-power-of-2 sizes are exact.
- move_pulse is high only if x_select or y_select changed on that edge. A blocked step gives no pulse.
- reveal_pulse / flag_pulse fire on the d rising edge of mostrar / mostrar_flag only; these buttons never auto-repeat.
  - Pulses are registered on the same edge as any concurrent cursor update, so consumers sample x_select/y_select in the pulse cycle and see the post-step position.

## Timing
- Reset values (asynchronous, immediate): x_select=0, y_select=0, all pulses 0, synchronisers 0, d=0, counters 0, FSMs IDLE.
- Press latency: a raw level first sampled high at edge 0 is synchronised at edge 2 and accepted (d=1) at edge 2+DEBOUNCE_CYCLES. The cursor update and pulse register at edge 3+DEBOUNCE_CYCLES.
- Hold: the second step occurs REPEAT_DELAY cycles after the first; each later step follows REPEAT_RATE cycles after the previous one.
- Release latency: symmetric, 2+DEBOUNCE_CYCLES edges to d=0. No step is issued after d falls.
- Glitches shorter than DEBOUNCE_CYCLES produce no activity.
- Reset asserted mid-hold or mid-debounce: on release, no pulse or step fires until a fresh qualifying press (high for DEBOUNCE_CYCLES after sync).
- Outputs are all registered; there are no combinational input-to-output paths.

## Test plan
Bench parameters: COLS=8, ROWS=6, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- Reset, then a derecha pulse of 3 cycles -> no change. derecha held 20 cycles -> x_select 0->1 at edge 7 after first sample, single move_pulse, then repeat at +10 -> x=2, at +13 -> x=3 (within the 20-cycle hold window plus release latency).
- WRAP=0, y at 5, abajo pressed -> y stays 5, no move_pulse. WRAP=1 same stimulus -> y=0 with move_pulse. izquierda at x=0 with WRAP=1 -> x=7.
- arriba and abajo held together from y=3 -> y stays 3, no move_pulse. arriba+derecha together from (2,3) -> (3,2) on one edge, one move_pulse.
- mostrar held 50 cycles -> exactly one reveal_pulse. mostrar_flag and derecha accepted on the same cycle -> flag_pulse coincides with the new x_select.
- Bouncy press (1/0 toggling every 2 cycles for 12 cycles, then stable high) -> exactly one step, DEBOUNCE_CYCLES+3 edges after the last transition.
- rst asserted while derecha held in REPEAT -> outputs 0 immediately. Button still held at reset release -> first step after 3+DEBOUNCE_CYCLES edges, then normal repeat.

Source files
------------

// File: rtl/grid_cursor_ctrl.sv
// rtl/grid_cursor_ctrl.sv - grid cursor controller with debounced buttons and hold-to-repeat
// Six raw buttons are synchronised and debounced; four drive repeat FSMs that step the cursor.
module grid_cursor_ctrl #(
  parameter int COLS            = 8,
  parameter int ROWS            = 8,
  parameter int X_W             = $clog2(COLS),
  parameter int Y_W             = $clog2(ROWS),
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int WRAP            = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           arriba,
  input  logic           abajo,
  input  logic           izquierda,
  input  logic           derecha,
  input  logic           mostrar,
  input  logic           mostrar_flag,
  output logic [X_W-1:0] x_select,
  output logic [Y_W-1:0] y_select,
  output logic           move_pulse,
  output logic           reveal_pulse,
  output logic           flag_pulse
);

  localparam int NCH  = 6;
  localparam int NDIR = 4;
  localparam int CH_ARRIBA    = 0;
  localparam int CH_ABAJO     = 1;
  localparam int CH_IZQUIERDA = 2;
  localparam int CH_DERECHA   = 3;
  localparam int CH_MOSTRAR   = 4;
  localparam int CH_FLAG      = 5;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RC_W = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [RC_W-1:0] DELAY_LAST = RC_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RC_W-1:0] RATE_LAST  = RC_W'(REPEAT_RATE - 1);
  localparam bit              REPEAT_EN  = (REPEAT_DELAY != 0);
  localparam bit              WRAP_EN    = (WRAP != 0);

  localparam logic [X_W-1:0] X_MAX = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(ROWS - 1);

  logic [NCH-1:0]  raw;
  logic [NCH-1:0]  sync_a;
  logic [NCH-1:0]  sync_b;
  logic [NCH-1:0]  deb;
  logic [1:0]      btn_q;
  logic [DB_W-1:0] db_cnt [NCH];

  assign raw = {mostrar_flag, mostrar, derecha, izquierda, abajo, arriba};

  // The debounced level only flips after the synchronised level has disagreed long enough;
  // any agreeing cycle restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      deb    <= '0;
      btn_q  <= '0;
      for (int i = 0; i < NCH; i++) db_cnt[i] <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      btn_q  <= deb[CH_FLAG:CH_MOSTRAR];
      for (int i = 0; i < NCH; i++) begin
        if (sync_b[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  typedef enum logic [1:0] {
    RP_IDLE,
    RP_DELAY,
    RP_REPEAT
  } rep_state_t;

  rep_state_t      rep_state [NDIR];
  logic [RC_W-1:0] rep_cnt   [NDIR];
  logic [NDIR-1:0] step;

  always_comb begin
    step = '0;
    for (int i = 0; i < NDIR; i++) begin
      case (rep_state[i])
        RP_IDLE:   step[i] = deb[i];
        RP_DELAY:  step[i] = deb[i] && REPEAT_EN && (rep_cnt[i] == DELAY_LAST);
        RP_REPEAT: step[i] = deb[i] && (rep_cnt[i] == RATE_LAST);
        default:   step[i] = 1'b0;
      endcase
    end
  end

  // IDLE is only ever occupied while the debounced level is low, so IDLE with d high is a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NDIR; i++) begin
        rep_state[i] <= RP_IDLE;
        rep_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NDIR; i++) begin
        if (!deb[i]) begin
          rep_state[i] <= RP_IDLE;
          rep_cnt[i]   <= '0;
        end else begin
          case (rep_state[i])
            RP_IDLE: begin
              rep_state[i] <= RP_DELAY;
              rep_cnt[i]   <= '0;
            end
            RP_DELAY: begin
              if (REPEAT_EN) begin
                if (rep_cnt[i] == DELAY_LAST) begin
                  rep_state[i] <= RP_REPEAT;
                  rep_cnt[i]   <= '0;
                end else begin
                  rep_cnt[i] <= rep_cnt[i] + RC_W'(1);
                end
              end
            end
            RP_REPEAT: begin
              if (rep_cnt[i] == RATE_LAST) rep_cnt[i] <= '0;
              else                         rep_cnt[i] <= rep_cnt[i] + RC_W'(1);
            end
            default: begin
              rep_state[i] <= RP_IDLE;
              rep_cnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  // Opposing requests on one axis cancel; the two axes are independent.
  logic           x_inc;
  logic           x_dec;
  logic           y_inc;
  logic           y_dec;
  logic [X_W-1:0] x_next;
  logic [Y_W-1:0] y_next;

  assign x_inc = step[CH_DERECHA]   & ~step[CH_IZQUIERDA];
  assign x_dec = step[CH_IZQUIERDA] & ~step[CH_DERECHA];
  assign y_inc = step[CH_ABAJO]     & ~step[CH_ARRIBA];
  assign y_dec = step[CH_ARRIBA]    & ~step[CH_ABAJO];

  always_comb begin
    x_next = x_select;
    if (x_inc) begin
      if (x_select == X_MAX) x_next = WRAP_EN ? '0 : X_MAX;
      else                   x_next = x_select + X_W'(1);
    end else if (x_dec) begin
      if (x_select == '0) x_next = WRAP_EN ? X_MAX : '0;
      else                x_next = x_select - X_W'(1);
    end
  end

  always_comb begin
    y_next = y_select;
    if (y_inc) begin
      if (y_select == Y_MAX) y_next = WRAP_EN ? '0 : Y_MAX;
      else                   y_next = y_select + Y_W'(1);
    end else if (y_dec) begin
      if (y_select == '0) y_next = WRAP_EN ? Y_MAX : '0;
      else                y_next = y_select - Y_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_select     <= '0;
      y_select     <= '0;
      move_pulse   <= 1'b0;
      reveal_pulse <= 1'b0;
      flag_pulse   <= 1'b0;
    end else begin
      x_select     <= x_next;
      y_select     <= y_next;
      move_pulse   <= (x_next != x_select) || (y_next != y_select);
      reveal_pulse <= deb[CH_MOSTRAR] & ~btn_q[0];
      flag_pulse   <= deb[CH_FLAG]    & ~btn_q[1];
    end
  end

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// tb/tb_grid_cursor_ctrl.sv - scoreboard bench for grid_cursor_ctrl (saturating and wrapping instances)
module tb_grid_cursor_ctrl;

  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RR   = 3;

  localparam logic [5:0] ARR = 6'b000001;
  localparam logic [5:0] ABA = 6'b000010;
  localparam logic [5:0] IZQ = 6'b000100;
  localparam logic [5:0] DER = 6'b001000;
  localparam logic [5:0] MOS = 6'b010000;
  localparam logic [5:0] FLG = 6'b100000;

  typedef struct {
    int at;
    int x;
    int y;
    bit mv;
    bit rv;
    bit fl;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] btn0;
  logic [5:0] btn1;
  logic [2:0] x0, y0, x1, y1;
  logic       mv0, rv0, fl0, mv1, rv1, fl1;

  ev_t q0[$];
  ev_t q1[$];
  int  edge_n = 0;
  int  n_cmp  = 0;
  int  n_bad  = 0;
  int  hold_steps[5] = '{7, 17, 20, 23, 26};

  always #5 clk = ~clk;
  always @(posedge clk) edge_n = edge_n + 1;

  grid_cursor_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .WRAP(0)
  ) dut_sat (
    .clk(clk), .rst(rst),
    .arriba(btn0[0]), .abajo(btn0[1]), .izquierda(btn0[2]), .derecha(btn0[3]),
    .mostrar(btn0[4]), .mostrar_flag(btn0[5]),
    .x_select(x0), .y_select(y0),
    .move_pulse(mv0), .reveal_pulse(rv0), .flag_pulse(fl0)
  );

  grid_cursor_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .WRAP(1)
  ) dut_wrap (
    .clk(clk), .rst(rst),
    .arriba(btn1[0]), .abajo(btn1[1]), .izquierda(btn1[2]), .derecha(btn1[3]),
    .mostrar(btn1[4]), .mostrar_flag(btn1[5]),
    .x_select(x1), .y_select(y1),
    .move_pulse(mv1), .reveal_pulse(rv1), .flag_pulse(fl1)
  );

  task automatic push(input int id, input int at, input int x, input int y,
                      input bit mv, input bit rv, input bit fl);
    ev_t e;
    e = '{at, x, y, mv, rv, fl};
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic mon(input int id, input logic [2:0] x, input logic [2:0] y,
                     input logic mv, input logic rv, input logic fl);
    ev_t e;
    bit  have;
    have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (id == 0) ? q0[0] : q1[0];
    if (have && e.at < edge_n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dut%0d missed_event: expected at edge %0d x=%0d y=%0d mv=%0b rv=%0b fl=%0b, absent at edge %0d",
               id, e.at, e.x, e.y, e.mv, e.rv, e.fl, edge_n);
      if (id == 0) void'(q0.pop_front());
      else         void'(q1.pop_front());
      have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) e = (id == 0) ? q0[0] : q1[0];
    end
    if (!(mv || rv || fl)) return;
    n_cmp++;
    if (!have) begin
      n_bad++;
      $display("FAIL dut%0d unexpected_pulse: edge %0d x=%0d y=%0d mv=%0b rv=%0b fl=%0b, required no pulse",
               id, edge_n, x, y, mv, rv, fl);
      return;
    end
    if (id == 0) void'(q0.pop_front());
    else         void'(q1.pop_front());
    if (e.at != edge_n || int'(x) != e.x || int'(y) != e.y || mv != e.mv || rv != e.rv || fl != e.fl) begin
      n_bad++;
      $display("FAIL dut%0d event: got edge %0d x=%0d y=%0d mv=%0b rv=%0b fl=%0b, required edge %0d x=%0d y=%0d mv=%0b rv=%0b fl=%0b",
               id, edge_n, x, y, mv, rv, fl, e.at, e.x, e.y, e.mv, e.rv, e.fl);
    end
  endtask

  always @(negedge clk) mon(0, x0, y0, mv0, rv0, fl0);
  always @(negedge clk) mon(1, x1, y1, mv1, rv1, fl1);

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int id, input logic [5:0] m);
    if (id == 0) btn0 = m;
    else         btn1 = m;
  endtask

  task automatic hold(input int id, input logic [5:0] m, input int n);
    drive(id, m);
    cycles(n);
    drive(id, 6'b0);
    cycles(12);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    rst  = 1'b1;
    btn0 = '0;
    btn1 = '0;
    cycles(3);
    chk("reset_x", int'(x0), 0);
    chk("reset_y", int'(y0), 0);
    chk("reset_pulses", int'({mv0, rv0, fl0}), 0);
    chk("reset_wrap_xy", int'({x1, y1}), 0);
    rst = 1'b0;
    cycles(2);

    hold(0, DER, 3);
    chk("glitch_x", int'(x0), 0);

    t = edge_n + 1;
    for (int k = 0; k < 5; k++) push(0, t + hold_steps[k], k + 1, 0, 1, 0, 0);
    hold(0, DER, 20);

    t = edge_n + 1;
    for (int k = 0; k < 5; k++) push(0, t + hold_steps[k], 5, k + 1, 1, 0, 0);
    hold(0, ABA, 20);

    hold(0, ABA, 8);
    chk("saturate_y", int'(y0), 5);

    t = edge_n + 1;
    for (int k = 0; k < 5; k++) push(1, t + hold_steps[k], 0, k + 1, 1, 0, 0);
    hold(1, ABA, 20);
    t = edge_n + 1;
    push(1, t + 7, 0, 0, 1, 0, 0);
    hold(1, ABA, 8);
    t = edge_n + 1;
    push(1, t + 7, 7, 0, 1, 0, 0);
    hold(1, IZQ, 8);
    chk("wrap_x", int'(x1), 7);

    t = edge_n + 1;
    push(0, t + 7, 5, 4, 1, 0, 0);
    hold(0, ARR, 8);
    t = edge_n + 1;
    push(0, t + 7, 5, 3, 1, 0, 0);
    hold(0, ARR, 8);
    hold(0, ARR | ABA, 8);
    chk("cancel_y", int'(y0), 3);

    for (int k = 0; k < 3; k++) begin
      t = edge_n + 1;
      push(0, t + 7, 4 - k, 3, 1, 0, 0);
      hold(0, IZQ, 8);
    end

    t = edge_n + 1;
    push(0, t + 7, 3, 2, 1, 0, 0);
    hold(0, ARR | DER, 8);

    t = edge_n + 1;
    push(0, t + 7, 3, 2, 0, 1, 0);
    hold(0, MOS, 50);

    t = edge_n + 1;
    push(0, t + 7, 4, 2, 1, 0, 1);
    hold(0, FLG | DER, 8);

    t = edge_n + 1;
    push(0, t + 19, 5, 2, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      drive(0, (((i / 2) % 2) == 0) ? DER : 6'b0);
      cycles(1);
    end
    hold(0, DER, 8);
    chk("bounce_x", int'(x0), 5);

    t = edge_n + 1;
    push(0, t + 7, 6, 2, 1, 0, 0);
    push(0, t + 17, 7, 2, 1, 0, 0);
    drive(0, DER);
    cycles(22);
    rst = 1'b1;
    #1;
    chk("midhold_reset_x", int'(x0), 0);
    chk("midhold_reset_y", int'(y0), 0);
    chk("midhold_reset_pulses", int'({mv0, rv0, fl0}), 0);
    chk("midhold_reset_wrap_xy", int'({x1, y1}), 0);
    cycles(3);
    rst = 1'b0;
    t = edge_n + 1;
    push(0, t + 7, 1, 0, 1, 0, 0);
    push(0, t + 17, 2, 0, 1, 0, 0);
    push(0, t + 20, 3, 0, 1, 0, 0);
    cycles(15);
    drive(0, 6'b0);
    cycles(20);
    chk("final_x", int'(x0), 3);

    chk("sat_queue_drained", q0.size(), 0);
    chk("wrap_queue_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
